reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Staged reset-release sequencer in the 125 MHz fabric domain, downstream of the clock/reset generator. Consumes the fabric reset and PLL-lock status and releases per-subsystem active-low resets one stage at a time, in order, waiting for each stage's ready handshake before releasing the next. On PLL-lock loss or a software request, re-asserts all stages in reverse order. Optionally flags a stage that never reports ready.

## Interface
Parameters:
- NUM_STAGES, 4, number of reset stages (1..8)
- HOLD_CYCLES, 16, cycles stage k is held released before its STAGE_READY is sampled (≥1)
- TIMEOUT_CYCLES, 65536, max cycles spent waiting for STAGE_READY[k] (≥2)

Ports:
- CLK  in  1  fabric clock (CLK_125MHz); one clock, all logic on rising edge
- RESETN  in  1  asynchronous, active-low reset (RESETN_125MHz)
- PLL_LOCK  in  1  combined PLL lock, asynchronous; 2-FF synchronised internally
- SOFT_RST_REQ  in  1  single-cycle request, synchronous to CLK
- STAGE_READY  in  NUM_STAGES  per-stage ready, synchronous to CLK
- STAGE_RESETN  out  NUM_STAGES  per-stage active-low reset, registered
- SEQ_DONE  out  1  all stages released and ready
- TIMEOUT_ERR  out  1  sticky, stage failed to report ready
- ERR_STAGE  out  3  index of failing stage

## Operation
- Reset (RESETN=0): STAGE_RESETN=0, SEQ_DONE=0, TIMEOUT_ERR=0, ERR_STAGE=0, k=0, state WAIT_LOCK, synchroniser cleared.
- WAIT_LOCK: on lock_sync=1 → RELEASE. SOFT_RST_REQ ignored.
- RELEASE: set STAGE_RESETN[k]=1, load hold counter with HOLD_CYCLES-1 → HOLD.
- HOLD: decrement; at 0 → WAIT_READY, clear timeout counter.
- WAIT_READY: STAGE_READY[k]=1 → if k=NUM_STAGES-1 → DONE (SEQ_DONE=1) else k+1 → RELEASE. Timeout counter reaching TIMEOUT_CYCLES-1 without ready → set TIMEOUT_ERR, ERR_STAGE=k → TEARDOWN.
- DONE: hold. lock_sync=0 or SOFT_RST_REQ=1 → TEARDOWN.
- TEARDOWN: each cycle clear STAGE_RESETN[k]; if k=0 → (TIMEOUT_ERR ? HALT : WAIT_LOCK) else k-1. SEQ_DONE cleared on entry.
- HALT: all stages in reset; SOFT_RST_REQ clears TIMEOUT_ERR and ERR_STAGE → WAIT_LOCK. lock_sync ignored.
- Invariant: STAGE_RESETN is always thermometer-coded (stage j released ⇒ all i<j released).
- lock_sync=0 in RELEASE/HOLD/WAIT_READY → TEARDOWN from current k (stage k cleared first).
- Priority in WAIT_READY: lock loss > timeout > ready.
- STAGE_READY[i≠k] ignored; STAGE_READY deassertion after release not monitored.
- SOFT_RST_REQ in RELEASE/HOLD/WAIT_READY → TEARDOWN (same as lock loss).
- RESETN asserted mid-sequence: all outputs to reset values immediately (asynchronous), no reverse-order teardown.

## Timing
- PLL_LOCK rise to lock_sync: 2 cycles; lock_sync to STAGE_RESETN[0] rise: 2 cycles (WAIT_LOCK→RELEASE, RELEASE registers output).
- STAGE_RESETN[k] rise to first READY sample: HOLD_CYCLES cycles.
- READY[k] already high: STAGE_RESETN[k+1] rises HOLD_CYCLES+2 cycles after STAGE_RESETN[k] (minimum spacing).
- READY of last stage sampled → SEQ_DONE high next cycle.
- Teardown trigger → top released stage and SEQ_DONE low next cycle; one stage per cycle thereafter; full teardown NUM_STAGES cycles.
- Timeout: TIMEOUT_ERR rises exactly TIMEOUT_CYCLES cycles after WAIT_READY entry.

## Configuration
- RSTSEQ_TIMEOUT_EN defined: timeout counter, TIMEOUT_ERR, ERR_STAGE, HALT state implemented as above.
- Not defined: WAIT_READY waits indefinitely; no timeout counter; TIMEOUT_ERR and ERR_STAGE tied 0; HALT unreachable.

## Test plan
- NUM_STAGES=4, HOLD_CYCLES=16, READY tied high, PLL_LOCK rises → stages release at 2-cycle offset 18-cycle spacing order 0,1,2,3; SEQ_DONE high 1 cycle after stage 3 ready sampled.
- READY[2] delayed 100 cycles → STAGE_RESETN[3] rises 2 cycles after READY[2]; no earlier.
- PLL_LOCK drops in DONE → after 2-cycle sync, SEQ_DONE low, stages clear 3,2,1,0 on consecutive cycles; re-lock reruns sequence.
- RSTSEQ_TIMEOUT_EN, TIMEOUT_CYCLES=1000, READY[1] never high → TIMEOUT_ERR=1, ERR_STAGE=1 at 1000 cycles into WAIT_READY; stages 1,0 cleared; HALT until SOFT_RST_REQ pulse clears error and resequences.
- SOFT_RST_REQ during HOLD of stage 2 → stages 2,1,0 cleared on 3 consecutive cycles; thermometer invariant checked every cycle.
- RESETN asserted while stage 1 in WAIT_READY → all outputs 0 asynchronously, same cycle.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Staged reset-release sequencer for the 125 MHz fabric domain. Once the
//   synchronised PLL lock is seen, per-subsystem active-low resets are released
//   one stage at a time (stage 0 first). Each released stage is held for
//   HOLD_CYCLES before its ready handshake is sampled. Lock loss or a software
//   request tears the stages back down in reverse order, one per cycle.
//
//   Optional feature, enabled by defining the macro RSTSEQ_TIMEOUT_EN:
//   a bounded wait for STAGE_READY. A stage that never reports ready sets the
//   sticky TIMEOUT_ERR and ERR_STAGE, triggers a teardown, and parks the
//   sequencer in HALT until SOFT_RST_REQ clears the error. Without the macro,
//   the wait is unbounded and TIMEOUT_ERR / ERR_STAGE are tied low.
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  PLL_LOCK,
  input  logic                  SOFT_RST_REQ,
  input  logic [NUM_STAGES-1:0] STAGE_READY,
  output logic [NUM_STAGES-1:0] STAGE_RESETN,
  output logic                  SEQ_DONE,
  output logic                  TIMEOUT_ERR,
  output logic [2:0]            ERR_STAGE
);

  // Hold counter counts HOLD_CYCLES-1 down to 0, so it needs clog2(HOLD_CYCLES) bits.
  localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]        LAST_K    = 3'(NUM_STAGES - 1);

`ifdef RSTSEQ_TIMEOUT_EN
  // Timeout counter counts 0 up to TIMEOUT_CYCLES-1.
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`endif

  // Out-of-range parameters elaborate this empty marker block so they show up
  // in the elaborated hierarchy; legal configurations never create it.
  if ((NUM_STAGES < 1) || (NUM_STAGES > 8) || (HOLD_CYCLES < 1) ||
      (TIMEOUT_CYCLES < 2)) begin : g_param_range_violation
  end

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_RELEASE,
    ST_HOLD,
    ST_WAIT_READY,
    ST_DONE,
    ST_TEARDOWN,
    ST_HALT
  } state_t;

  state_t                state_q, state_d;
  logic                  lock_meta_q, lock_meta_d;
  logic                  lock_sync_q, lock_sync_d;
  logic [2:0]            k_q, k_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  seq_done_q, seq_done_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;

`ifdef RSTSEQ_TIMEOUT_EN
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [2:0]            err_stage_q, err_stage_d;
`endif

  logic [NUM_STAGES-1:0] k_onehot;
  logic                  ready_k;
  logic                  abort;
  logic                  do_teardown;

  // Two-flop synchroniser for the asynchronous combined PLL lock.
  always_comb begin
    lock_meta_d = PLL_LOCK;
    lock_sync_d = lock_meta_q;
  end

  // Decode the current stage index into a one-hot select over the stage vector.
  always_comb begin
    k_onehot = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (k_q == 3'(i)) begin
        k_onehot[i] = 1'b1;
      end
    end
  end

  // Only the ready of the stage currently being brought up matters.
  assign ready_k = |(STAGE_READY & k_onehot);

  // Lock loss and software request both force a reverse-order teardown.
  assign abort = ~lock_sync_q | SOFT_RST_REQ;

  // Sequencer next-state logic. Any trigger performs the first teardown step
  // in the same cycle, so the top released stage drops one cycle after it.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    stage_d     = stage_q;
    seq_done_d  = seq_done_q;
    hold_d      = hold_q;
    do_teardown = 1'b0;
`ifdef RSTSEQ_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
    err_stage_d   = err_stage_q;
`endif

    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_sync_q) begin
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (abort) begin
          do_teardown = 1'b1;
        end else begin
          stage_d = stage_q | k_onehot;
          hold_d  = HOLD_LOAD;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (abort) begin
          do_teardown = 1'b1;
        end else if (hold_q == '0) begin
          state_d = ST_WAIT_READY;
`ifdef RSTSEQ_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      // Priority: lock loss / soft request, then timeout, then ready.
      ST_WAIT_READY: begin
        if (abort) begin
          do_teardown = 1'b1;
        end
`ifdef RSTSEQ_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          err_stage_d   = k_q;
          do_teardown   = 1'b1;
        end
`endif
        else if (ready_k) begin
          if (k_q == LAST_K) begin
            seq_done_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = ST_RELEASE;
          end
        end
`ifdef RSTSEQ_TIMEOUT_EN
        else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end

      ST_DONE: begin
        if (abort) begin
          do_teardown = 1'b1;
        end
      end

      ST_TEARDOWN: begin
        do_teardown = 1'b1;
      end

      ST_HALT: begin
`ifdef RSTSEQ_TIMEOUT_EN
        // Lock is ignored here; only software may clear the error and restart.
        if (SOFT_RST_REQ) begin
          timeout_err_d = 1'b0;
          err_stage_d   = '0;
          state_d       = ST_WAIT_LOCK;
        end
`else
        state_d = ST_WAIT_LOCK;
`endif
      end

      default: begin
        state_d = ST_WAIT_LOCK;
      end
    endcase

    // One teardown step: drop stage k, then step down or finish.
    if (do_teardown) begin
      stage_d    = stage_q & ~k_onehot;
      seq_done_d = 1'b0;
      if (k_q == 3'd0) begin
`ifdef RSTSEQ_TIMEOUT_EN
        state_d = timeout_err_d ? ST_HALT : ST_WAIT_LOCK;
`else
        state_d = ST_WAIT_LOCK;
`endif
      end else begin
        k_d     = k_q - 3'd1;
        state_d = ST_TEARDOWN;
      end
    end
  end

  // State and output registers; RESETN drops every stage immediately.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      state_q     <= ST_WAIT_LOCK;
      k_q         <= '0;
      stage_q     <= '0;
      seq_done_q  <= 1'b0;
      hold_q      <= '0;
`ifdef RSTSEQ_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
      err_stage_q   <= '0;
`endif
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
      state_q     <= state_d;
      k_q         <= k_d;
      stage_q     <= stage_d;
      seq_done_q  <= seq_done_d;
      hold_q      <= hold_d;
`ifdef RSTSEQ_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
      err_stage_q   <= err_stage_d;
`endif
    end
  end

  assign STAGE_RESETN = stage_q;
  assign SEQ_DONE     = seq_done_q;

`ifdef RSTSEQ_TIMEOUT_EN
  assign TIMEOUT_ERR = timeout_err_q;
  assign ERR_STAGE   = err_stage_q;
`else
  assign TIMEOUT_ERR = 1'b0;
  assign ERR_STAGE   = 3'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer (NUM_STAGES=4, HOLD_CYCLES=16,
// TIMEOUT_CYCLES=1000). Inputs change and outputs are sampled on the falling
// clock edge; cycle numbers count rising edges since the triggering input change.
`timescale 1ns/1ps
module tb_reset_sequencer;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       PLL_LOCK;
  logic       SOFT_RST_REQ;
  logic [3:0] STAGE_READY;
  logic [3:0] STAGE_RESETN;
  logic       SEQ_DONE;
  logic       TIMEOUT_ERR;
  logic [2:0] ERR_STAGE;

  int vectors     = 0;
  int miscompares = 0;

  // Expected stage vector 1..6 cycles after PLL_LOCK drops while in DONE.
  localparam logic [3:0] DROP_STAGE[6] = '{4'hF, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
  localparam logic       DROP_DONE[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 CLK = ~CLK;

  reset_sequencer #(
    .NUM_STAGES    (4),
    .HOLD_CYCLES   (16),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .PLL_LOCK    (PLL_LOCK),
    .SOFT_RST_REQ(SOFT_RST_REQ),
    .STAGE_READY (STAGE_READY),
    .STAGE_RESETN(STAGE_RESETN),
    .SEQ_DONE    (SEQ_DONE),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .ERR_STAGE   (ERR_STAGE)
  );

  function automatic bit is_therm(input logic [3:0] v);
    return (v === 4'b0000) || (v === 4'b0001) || (v === 4'b0011) ||
           (v === 4'b0111) || (v === 4'b1111);
  endfunction

  // Synchronous-looking reset pulse; returns on the falling edge where RESETN rises.
  task automatic pulse_reset();
    @(negedge CLK);
    RESETN = 1'b0;
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
  endtask

  task automatic test_reset();
    RESETN       = 1'b0;
    PLL_LOCK     = 1'b0;
    SOFT_RST_REQ = 1'b0;
    STAGE_READY  = 4'h0;
    repeat (3) @(negedge CLK);
    vectors++;
    if (STAGE_RESETN !== 4'h0) begin
      $display("FAIL reset_stage_resetn: got %b want %b", STAGE_RESETN, 4'h0);
      miscompares++;
    end
    vectors++;
    if (SEQ_DONE !== 1'b0) begin
      $display("FAIL reset_seq_done: got %b want 0", SEQ_DONE);
      miscompares++;
    end
    vectors++;
    if (TIMEOUT_ERR !== 1'b0) begin
      $display("FAIL reset_timeout_err: got %b want 0", TIMEOUT_ERR);
      miscompares++;
    end
    vectors++;
    if (ERR_STAGE !== 3'd0) begin
      $display("FAIL reset_err_stage: got %0d want 0", ERR_STAGE);
      miscompares++;
    end
    // Out of reset with no lock: soft request must not start anything.
    RESETN = 1'b1;
    @(negedge CLK);
    SOFT_RST_REQ = 1'b1;
    @(negedge CLK);
    SOFT_RST_REQ = 1'b0;
    repeat (8) @(negedge CLK);
    vectors++;
    if (STAGE_RESETN !== 4'h0 || SEQ_DONE !== 1'b0) begin
      $display("FAIL wait_lock_idle: got stages %b done %b want 0000 0", STAGE_RESETN, SEQ_DONE);
      miscompares++;
    end
  endtask

  // Starts in WAIT_LOCK with lock low; READY tied high.
  task automatic test_sequence(input string tag);
    int first_rise[4];
    int done_at;
    int therm_bad;
    for (int i = 0; i < 4; i++) first_rise[i] = -1;
    done_at   = -1;
    therm_bad = 0;
    STAGE_READY = 4'hF;
    PLL_LOCK    = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
        if (first_rise[i] < 0 && STAGE_RESETN[i] === 1'b1) first_rise[i] = c;
      end
      if (done_at < 0 && SEQ_DONE === 1'b1) done_at = c;
      if (!is_therm(STAGE_RESETN)) therm_bad++;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (first_rise[i] != 4 + 18 * i) begin
        $display("FAIL %s_stage%0d_rise: got cycle %0d want %0d", tag, i, first_rise[i], 4 + 18 * i);
        miscompares++;
      end
    end
    vectors++;
    if (done_at != 75) begin
      $display("FAIL %s_seq_done_rise: got cycle %0d want 75", tag, done_at);
      miscompares++;
    end
    vectors++;
    if (therm_bad != 0) begin
      $display("FAIL %s_thermometer: got %0d bad cycles want 0", tag, therm_bad);
      miscompares++;
    end
    vectors++;
    if (STAGE_RESETN !== 4'hF || SEQ_DONE !== 1'b1) begin
      $display("FAIL %s_final: got stages %b done %b want 1111 1", tag, STAGE_RESETN, SEQ_DONE);
      miscompares++;
    end
  endtask

  // Starts in DONE; lock drop is seen after the synchroniser, then 3,2,1,0 clear.
  task automatic test_pll_drop();
    PLL_LOCK = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      vectors++;
      if (STAGE_RESETN !== DROP_STAGE[c-1]) begin
        $display("FAIL drop_stage_c%0d: got %b want %b", c, STAGE_RESETN, DROP_STAGE[c-1]);
        miscompares++;
      end
      vectors++;
      if (SEQ_DONE !== DROP_DONE[c-1]) begin
        $display("FAIL drop_done_c%0d: got %b want %b", c, SEQ_DONE, DROP_DONE[c-1]);
        miscompares++;
      end
    end
    repeat (4) @(negedge CLK);
    vectors++;
    if (STAGE_RESETN !== 4'h0) begin
      $display("FAIL drop_stays_down: got %b want 0000", STAGE_RESETN);
      miscompares++;
    end
  endtask

  // Starts in DONE with lock high: soft teardown, auto-restart, then soft in HOLD of stage 2.
  task automatic test_soft_teardown();
    logic [3:0] exp;
    bit         chk;
    int         therm_bad;
    therm_bad    = 0;
    SOFT_RST_REQ = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge CLK);
      if (c == 1) SOFT_RST_REQ = 1'b0;
      chk = 1'b1;
      exp = 4'h0;
      case (c)
        1:  exp = 4'h7;
        2:  exp = 4'h3;
        3:  exp = 4'h1;
        4:  exp = 4'h0;
        5:  exp = 4'h0;
        6:  exp = 4'h1;
        23: exp = 4'h1;
        24: exp = 4'h3;
        42: exp = 4'h7;
        45: exp = 4'h7;
        46: exp = 4'h3;
        47: exp = 4'h1;
        48: exp = 4'h0;
        49: exp = 4'h0;
        50: exp = 4'h1;
        default: chk = 1'b0;
      endcase
      if (chk) begin
        vectors++;
        if (STAGE_RESETN !== exp) begin
          $display("FAIL soft_stage_c%0d: got %b want %b", c, STAGE_RESETN, exp);
          miscompares++;
        end
      end
      if (!is_therm(STAGE_RESETN) || SEQ_DONE !== 1'b0) therm_bad++;
      if (c == 45) SOFT_RST_REQ = 1'b1;
      if (c == 46) SOFT_RST_REQ = 1'b0;
    end
    vectors++;
    if (therm_bad != 0) begin
      $display("FAIL soft_thermometer_done: got %0d bad cycles want 0", therm_bad);
      miscompares++;
    end
  endtask

  // READY[2] held low for 100 cycles of WAIT_READY; stage 3 must wait for it.
  task automatic test_ready_delay();
    int rise2, rise3, done_at, therm_bad;
    rise2 = -1; rise3 = -1; done_at = -1; therm_bad = 0;
    STAGE_READY = 4'b1011;
    PLL_LOCK    = 1'b1;
    pulse_reset();
    for (int c = 1; c <= 180; c++) begin
      @(negedge CLK);
      if (rise2 < 0 && STAGE_RESETN[2] === 1'b1) rise2 = c;
      if (rise3 < 0 && STAGE_RESETN[3] === 1'b1) rise3 = c;
      if (done_at < 0 && SEQ_DONE === 1'b1) done_at = c;
      if (!is_therm(STAGE_RESETN)) therm_bad++;
      if (c == 156) STAGE_READY = 4'hF;
    end
    vectors++;
    if (rise2 != 40) begin
      $display("FAIL delay_stage2_rise: got cycle %0d want 40", rise2);
      miscompares++;
    end
    vectors++;
    if (rise3 != 158) begin
      $display("FAIL delay_stage3_rise: got cycle %0d want 158", rise3);
      miscompares++;
    end
    vectors++;
    if (done_at != 175) begin
      $display("FAIL delay_seq_done_rise: got cycle %0d want 175", done_at);
      miscompares++;
    end
    vectors++;
    if (therm_bad != 0) begin
      $display("FAIL delay_thermometer: got %0d bad cycles want 0", therm_bad);
      miscompares++;
    end
  endtask

  // READY[1] never rises; stage 1 enters WAIT_READY on cycle 38.
  task automatic test_timeout();
    STAGE_READY = 4'b1101;
    PLL_LOCK    = 1'b1;
    pulse_reset();
`ifdef RSTSEQ_TIMEOUT_EN
    for (int c = 1; c <= 1064; c++) begin
      @(negedge CLK);
      if (c == 1037) begin
        vectors++;
        if (TIMEOUT_ERR !== 1'b0 || STAGE_RESETN !== 4'h3) begin
          $display("FAIL timeout_before: got err %b stages %b want 0 0011", TIMEOUT_ERR, STAGE_RESETN);
          miscompares++;
        end
      end
      if (c == 1038) begin
        vectors++;
        if (TIMEOUT_ERR !== 1'b1 || ERR_STAGE !== 3'd1) begin
          $display("FAIL timeout_flag: got err %b stage %0d want 1 1", TIMEOUT_ERR, ERR_STAGE);
          miscompares++;
        end
        vectors++;
        if (STAGE_RESETN !== 4'h1) begin
          $display("FAIL timeout_first_clear: got %b want 0001", STAGE_RESETN);
          miscompares++;
        end
      end
      if (c == 1039) begin
        vectors++;
        if (STAGE_RESETN !== 4'h0) begin
          $display("FAIL timeout_second_clear: got %b want 0000", STAGE_RESETN);
          miscompares++;
        end
      end
      if (c == 1060) begin
        vectors++;
        if (STAGE_RESETN !== 4'h0 || TIMEOUT_ERR !== 1'b1 || ERR_STAGE !== 3'd1) begin
          $display("FAIL halt_hold: got stages %b err %b stage %0d want 0000 1 1",
                   STAGE_RESETN, TIMEOUT_ERR, ERR_STAGE);
          miscompares++;
        end
        SOFT_RST_REQ = 1'b1;
      end
      if (c == 1061) begin
        SOFT_RST_REQ = 1'b0;
        vectors++;
        if (TIMEOUT_ERR !== 1'b0 || ERR_STAGE !== 3'd0) begin
          $display("FAIL halt_clear: got err %b stage %0d want 0 0", TIMEOUT_ERR, ERR_STAGE);
          miscompares++;
        end
      end
      if (c == 1062 || c == 1063) begin
        vectors++;
        if (STAGE_RESETN !== ((c == 1063) ? 4'h1 : 4'h0)) begin
          $display("FAIL halt_resequence_c%0d: got %b want %b", c, STAGE_RESETN,
                   (c == 1063) ? 4'h1 : 4'h0);
          miscompares++;
        end
      end
    end
`else
    for (int c = 1; c <= 1100; c++) begin
      @(negedge CLK);
      if (c == 45 || c == 1100) begin
        vectors++;
        if (STAGE_RESETN !== 4'h3 || TIMEOUT_ERR !== 1'b0 || ERR_STAGE !== 3'd0) begin
          $display("FAIL no_timeout_c%0d: got stages %b err %b stage %0d want 0011 0 0",
                   c, STAGE_RESETN, TIMEOUT_ERR, ERR_STAGE);
          miscompares++;
        end
      end
    end
`endif
  endtask

  // RESETN asserted mid-cycle must clear outputs without waiting for a clock edge.
  task automatic test_async_reset();
    STAGE_READY = 4'b1101;
    PLL_LOCK    = 1'b1;
    pulse_reset();
    repeat (45) @(negedge CLK);
    vectors++;
    if (STAGE_RESETN !== 4'h3) begin
      $display("FAIL async_pre_wait_ready: got %b want 0011", STAGE_RESETN);
      miscompares++;
    end
    #2 RESETN = 1'b0;
    #1;
    vectors++;
    if (STAGE_RESETN !== 4'h0 || SEQ_DONE !== 1'b0 || TIMEOUT_ERR !== 1'b0 || ERR_STAGE !== 3'd0) begin
      $display("FAIL async_wait_ready: got stages %b done %b err %b stage %0d want 0000 0 0 0",
               STAGE_RESETN, SEQ_DONE, TIMEOUT_ERR, ERR_STAGE);
      miscompares++;
    end
    // Same again from DONE, where SEQ_DONE is high.
    @(negedge CLK);
    RESETN      = 1'b1;
    STAGE_READY = 4'hF;
    repeat (80) @(negedge CLK);
    vectors++;
    if (STAGE_RESETN !== 4'hF || SEQ_DONE !== 1'b1) begin
      $display("FAIL async_pre_done: got stages %b done %b want 1111 1", STAGE_RESETN, SEQ_DONE);
      miscompares++;
    end
    #2 RESETN = 1'b0;
    #1;
    vectors++;
    if (STAGE_RESETN !== 4'h0 || SEQ_DONE !== 1'b0) begin
      $display("FAIL async_done: got stages %b done %b want 0000 0", STAGE_RESETN, SEQ_DONE);
      miscompares++;
    end
    @(negedge CLK);
    RESETN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequence("seq");
    test_pll_drop();
    test_sequence("relock");
    test_soft_teardown();
    test_ready_delay();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
